// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS32 writeback path: result select, load size, and
// the fixed register-zero and link-offset constants.
package mips_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_LOAD = 2'd1,
        RES_LINK = 2'd2
    } res_sel_e;

    typedef enum logic [1:0] {
        LD_B = 2'd0,
        LD_H = 2'd1,
        LD_W = 2'd2
    } ld_size_e;

    localparam logic [4:0]  REG_ZERO    = 5'd0;
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    // Size 3 behaves as a word access, so any access with size[1] set needs word alignment.
    function automatic logic ld_misaligned(input logic [1:0] size, input logic [1:0] off);
        return ((size == LD_H) && off[0]) || (size[1] && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mips_load_fmt.sv
// Little-endian load formatter: selects the byte/half/word lane from an aligned
// memory word and sign- or zero-extends it to 32 bits. Purely combinational.
module mips_load_fmt
    import mips_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [1:0]  off,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{off, 3'b000} +: 8];
        half_lane = off[1] ? word[31:16] : word[15:0];
        case (size)
            LD_B:    data = {{24{~uns & byte_lane[7]}}, byte_lane};
            LD_H:    data = {{16{~uns & half_lane[15]}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mips_wb_stage.sv
// MEM/WB pipeline register and writeback formatter driving the register bank write port.
// Define WB_FORWARD_EN to add the writeback-to-decode forwarding compare ports.
module mips_wb_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          stall,
    input  logic          flush,
    input  logic          in_reg_write,
    input  logic [AW-1:0] in_rd_addr,
    input  logic [1:0]    in_res_sel,
    input  logic [DW-1:0] in_alu_res,
    input  logic [DW-1:0] in_mem_data,
    input  logic [DW-1:0] in_pc,
    input  logic [1:0]    in_ld_size,
    input  logic          in_ld_uns,
    input  logic [1:0]    in_byte_off,
`ifdef WB_FORWARD_EN
    input  logic [AW-1:0] fwd_addr1,
    input  logic [AW-1:0] fwd_addr2,
    output logic          fwd_hit1,
    output logic          fwd_hit2,
    output logic [DW-1:0] fwd_data,
`endif
    output logic          rw_en,
    output logic [AW-1:0] rw_addr,
    output logic [DW-1:0] rw_data,
    output logic          align_err,
    output logic [31:0]   retired_cnt
);

    // Handshake: a transfer from the memory stage happens on a rising edge where
    // in_valid && in_ready (in_ready == !stall); flush overrides and drops the beat.
    assign in_ready = !stall;

    logic          wb_valid;
    logic          wb_reg_write;
    logic [AW-1:0] wb_rd_addr;
    logic [1:0]    wb_res_sel;
    logic [DW-1:0] wb_alu_res;
    logic [DW-1:0] wb_mem_data;
    logic [DW-1:0] wb_pc;
    logic [1:0]    wb_ld_size;
    logic          wb_ld_uns;
    logic [1:0]    wb_byte_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_rd_addr   <= '0;
            wb_res_sel   <= 2'd0;
            wb_alu_res   <= '0;
            wb_mem_data  <= '0;
            wb_pc        <= '0;
            wb_ld_size   <= 2'd0;
            wb_ld_uns    <= 1'b0;
            wb_byte_off  <= 2'd0;
        end else if (flush) begin
            wb_valid <= 1'b0;
        end else if (!stall) begin
            wb_valid <= in_valid;
            if (in_valid) begin
                wb_reg_write <= in_reg_write;
                wb_rd_addr   <= in_rd_addr;
                wb_res_sel   <= in_res_sel;
                wb_alu_res   <= in_alu_res;
                wb_mem_data  <= in_mem_data;
                wb_pc        <= in_pc;
                wb_ld_size   <= in_ld_size;
                wb_ld_uns    <= in_ld_uns;
                wb_byte_off  <= in_byte_off;
            end
        end
    end

    // Suppressed writes ($zero, misaligned) still count as retired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= 32'd0;
        end else if (wb_valid && !stall) begin
            retired_cnt <= retired_cnt + 32'd1;
        end
    end

    logic [DW-1:0] load_data;

    mips_load_fmt u_load_fmt (
        .word (wb_mem_data),
        .size (wb_ld_size),
        .uns  (wb_ld_uns),
        .off  (wb_byte_off),
        .data (load_data)
    );

    assign align_err = wb_valid && (wb_res_sel == RES_LOAD)
                       && ld_misaligned(wb_ld_size, wb_byte_off);

    always_comb begin
        case (wb_res_sel)
            RES_LOAD: rw_data = load_data;
            RES_LINK: rw_data = wb_pc + LINK_OFFSET;
            default:  rw_data = wb_alu_res;
        endcase
    end

    // A stalled instruction holds rw_en low until its final, unstalled cycle.
    assign rw_en   = wb_valid && wb_reg_write && (wb_rd_addr != REG_ZERO) && !align_err && !stall;
    assign rw_addr = wb_rd_addr;

`ifdef WB_FORWARD_EN
    assign fwd_hit1 = rw_en && (fwd_addr1 == rw_addr);
    assign fwd_hit2 = rw_en && (fwd_addr2 == rw_addr);
    assign fwd_data = rw_data;
`endif

endmodule

// File: tb/tb_mips_wb_stage.sv
// Directed bench for mips_wb_stage: ALU/load/link writeback, $zero and misaligned
// suppression, stall/flush handling and asynchronous reset.
module tb_mips_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic        flush;
    logic        in_reg_write;
    logic [4:0]  in_rd_addr;
    logic [1:0]  in_res_sel;
    logic [31:0] in_alu_res;
    logic [31:0] in_mem_data;
    logic [31:0] in_pc;
    logic [1:0]  in_ld_size;
    logic        in_ld_uns;
    logic [1:0]  in_byte_off;
    logic        rw_en;
    logic [4:0]  rw_addr;
    logic [31:0] rw_data;
    logic        align_err;
    logic [31:0] retired_cnt;
`ifdef WB_FORWARD_EN
    logic [4:0]  fwd_addr1;
    logic [4:0]  fwd_addr2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [31:0] fwd_data;
    assign fwd_addr1 = 5'd3;
    assign fwd_addr2 = 5'd31;
`endif

    mips_wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .stall        (stall),
        .flush        (flush),
        .in_reg_write (in_reg_write),
        .in_rd_addr   (in_rd_addr),
        .in_res_sel   (in_res_sel),
        .in_alu_res   (in_alu_res),
        .in_mem_data  (in_mem_data),
        .in_pc        (in_pc),
        .in_ld_size   (in_ld_size),
        .in_ld_uns    (in_ld_uns),
        .in_byte_off  (in_byte_off),
`ifdef WB_FORWARD_EN
        .fwd_addr1    (fwd_addr1),
        .fwd_addr2    (fwd_addr2),
        .fwd_hit1     (fwd_hit1),
        .fwd_hit2     (fwd_hit2),
        .fwd_data     (fwd_data),
`endif
        .rw_en        (rw_en),
        .rw_addr      (rw_addr),
        .rw_data      (rw_data),
        .align_err    (align_err),
        .retired_cnt  (retired_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_ret  = 0;
    logic [36:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write pulse seen at the falling edge must match the next expected write.
    always @(negedge clk) begin
        if (rst_n && rw_en) begin
            chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) chk("sb_write", {27'd0, rw_addr, rw_data}, 64'(exp_q.pop_front()));
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                             input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                             input logic [1:0] size, input logic uns, input logic [1:0] off);
        in_valid     = 1'b1;
        in_reg_write = rw;
        in_rd_addr   = rd;
        in_res_sel   = sel;
        in_alu_res   = alu;
        in_mem_data  = mem;
        in_pc        = pc;
        in_ld_size   = size;
        in_ld_uns    = uns;
        in_byte_off  = off;
    endtask

    // Scramble the inputs after capture: outputs must depend only on the stage register.
    task automatic scramble();
        in_valid    = 1'b0;
        in_rd_addr  = 5'($urandom_range(0, 31));
        in_alu_res  = $urandom;
        in_mem_data = $urandom;
        in_pc       = $urandom;
        in_res_sel  = 2'($urandom_range(0, 3));
        in_byte_off = 2'($urandom_range(0, 3));
        #1;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] addr,
                            input logic [31:0] data, input logic aerr);
        chk({tag, "_en"},   64'(rw_en),     64'(en));
        chk({tag, "_addr"}, 64'(rw_addr),   64'(addr));
        chk({tag, "_data"}, 64'(rw_data),   64'(data));
        chk({tag, "_aerr"}, 64'(align_err), 64'(aerr));
    endtask

    task automatic run_case(input string tag, input logic [4:0] rd, input logic [1:0] sel,
                            input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                            input logic [1:0] size, input logic uns, input logic [1:0] off,
                            input logic exp_en, input logic [31:0] exp_data, input logic exp_aerr);
        set_instr(1'b1, rd, sel, alu, mem, pc, size, uns, off);
        if (exp_en) exp_q.push_back({rd, exp_data});
        step();
        scramble();
        check_wb(tag, exp_en, rd, exp_data, exp_aerr);
        chk({tag, "_ret_hold"}, 64'(retired_cnt), 64'(exp_ret));
        step();
        exp_ret++;
        chk({tag, "_ret"}, 64'(retired_cnt), 64'(exp_ret));
        chk({tag, "_idle_en"}, 64'(rw_en), 64'd0);
    endtask

    localparam logic [31:0] LDW = 32'h8899AABB;

    initial begin
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        set_instr(1'b0, 5'd0, 2'd0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 2'd0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_wb("reset", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("reset_ret", 64'(retired_cnt), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU, loads, link, reserved select
        run_case("alu",      5'd3,  2'd0, 32'h7, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h7, 1'b0);
        run_case("lb_off1",  5'd4,  2'd1, 32'h0, LDW, 32'h0, 2'd0, 1'b0, 2'd1, 1'b1, 32'hFFFFFFAA, 1'b0);
        run_case("lbu_off3", 5'd5,  2'd1, 32'h0, LDW, 32'h0, 2'd0, 1'b1, 2'd3, 1'b1, 32'h00000088, 1'b0);
        run_case("lh_off2",  5'd6,  2'd1, 32'h0, LDW, 32'h0, 2'd1, 1'b0, 2'd2, 1'b1, 32'hFFFF8899, 1'b0);
        run_case("lhu_off0", 5'd7,  2'd1, 32'h0, LDW, 32'h0, 2'd1, 1'b1, 2'd0, 1'b1, 32'h0000AABB, 1'b0);
        run_case("lb_off0",  5'd8,  2'd1, 32'h0, LDW, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hFFFFFFBB, 1'b0);
        run_case("lbu_off2", 5'd9,  2'd1, 32'h0, 32'h00770000, 32'h0, 2'd0, 1'b1, 2'd2, 1'b1, 32'h00000077, 1'b0);
        run_case("lw",       5'd10, 2'd1, 32'h0, LDW, 32'h0, 2'd2, 1'b0, 2'd0, 1'b1, LDW, 1'b0);
        run_case("ld_sz3",   5'd11, 2'd1, 32'h0, LDW, 32'h0, 2'd3, 1'b0, 2'd0, 1'b1, LDW, 1'b0);
        run_case("link",     5'd31, 2'd2, 32'h0, 32'h0, 32'h00400010, 2'd0, 1'b0, 2'd0, 1'b1, 32'h00400018, 1'b0);
        run_case("link_wrap",5'd31, 2'd2, 32'h0, 32'h0, 32'hFFFFFFFC, 2'd0, 1'b0, 2'd0, 1'b1, 32'h00000004, 1'b0);
        run_case("res_rsvd", 5'd12, 2'd3, 32'hCAFE0001, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 32'hCAFE0001, 1'b0);

        // suppressed writes: $zero destination and misaligned loads
        run_case("rd_zero",  5'd0,  2'd0, 32'h55, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b0, 32'h55, 1'b0);
        run_case("lh_mis",   5'd13, 2'd1, 32'h0, LDW, 32'h0, 2'd1, 1'b0, 2'd1, 1'b0, 32'hFFFFAABB, 1'b1);
        run_case("lw_mis",   5'd14, 2'd1, 32'h0, LDW, 32'h0, 2'd2, 1'b0, 2'd2, 1'b0, LDW, 1'b1);

        // stall three cycles: no write while held, one pulse on release
        set_instr(1'b1, 5'd20, 2'd0, 32'h1234ABCD, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
        step();
        stall = 1'b1;
        set_instr(1'b1, 5'd21, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
        #1;
        chk("stall_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_en", 64'(rw_en), 64'd0);
            step();
            chk("stall_ret", 64'(retired_cnt), 64'(exp_ret));
        end
        chk("stall_hold_data", 64'(rw_data), 64'h1234ABCD);
        exp_q.push_back({5'd20, 32'h1234ABCD});
        stall = 1'b0;
        in_valid = 1'b0;
        #1;
        check_wb("stall_rel", 1'b1, 5'd20, 32'h1234ABCD, 1'b0);
        step();
        exp_ret++;
        chk("stall_rel_ret", 64'(retired_cnt), 64'(exp_ret));
        chk("stall_rel_idle", 64'(rw_en), 64'd0);

        // flush together with stall kills the held instruction
        set_instr(1'b1, 5'd22, 2'd0, 32'h0BAD0BAD, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
        step();
        in_valid = 1'b0;
        stall = 1'b1;
        flush = 1'b1;
        #1;
        chk("flush_st_en", 64'(rw_en), 64'd0);
        step();
        stall = 1'b0;
        flush = 1'b0;
        #1;
        chk("flush_st_after", 64'(rw_en), 64'd0);
        chk("flush_st_ret", 64'(retired_cnt), 64'(exp_ret));
        step();
        chk("flush_st_ret2", 64'(retired_cnt), 64'(exp_ret));

        // flush blocks capture of an incoming instruction
        set_instr(1'b1, 5'd23, 2'd0, 32'h00000023, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_cap_en", 64'(rw_en), 64'd0);

        // asynchronous reset while an instruction is stalled in the stage
        set_instr(1'b1, 5'd5, 2'd2, 32'h0, 32'h0, 32'h00001000, 2'd0, 1'b0, 2'd0);
        step();
        in_valid = 1'b0;
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_wb("arst", 1'b0, 5'd0, 32'd0, 1'b0);
        chk("arst_ret", 64'(retired_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        exp_ret = 0;
        step();
        chk("arst_rel_en", 64'(rw_en), 64'd0);
        chk("arst_rel_ret", 64'(retired_cnt), 64'd0);

        run_case("post_rst", 5'd9, 2'd0, 32'h600DF00D, 32'h0, 32'h0, 2'd0, 1'b0, 2'd0, 1'b1, 32'h600DF00D, 1'b0);

        repeat (2) step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
